// File: rtl/dm_pkg.sv
// Shared debug-module definitions: DTM operation codes, DMI status codes
// and the fixed low part of the DMI access data register.
package dm_pkg;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'd0,
        DTM_ERR     = 2'd2,
        DTM_BUSY    = 2'd3
    } dtm_op_status_e;

    // Low 34 bits of the DMI DR. The address field sits above it and its
    // width is a parameter of the DR module, so it is prepended there.
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_dr_t;

endpackage

// File: rtl/dmi_access_dr.sv
// DMI access data register of the JTAG DTM: captures/shifts/updates the
// {addr, data, op} DR and turns accepted updates into DMI bus requests.
// Optional build macro DMI_HARDRESET_EN: when defined, dmi_hardreset_i
// aborts any outstanding transaction and clears the sticky error.
//
// state    | meaning
// ---------+------------------------------------------------
// Idle     | no transaction outstanding, updates accepted
// Read     | read request presented, waiting for req ready
// Write    | write request presented, waiting for req ready
// WaitResp | request taken, waiting for the response
module dmi_access_dr
    import dm_pkg::*;
#(
    parameter int AddrWidth = 7
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 test_logic_reset_i,
    input  logic                 dmi_access_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 dmi_tdi_i,
    input  logic                 dmi_reset_i,
    input  logic                 dmi_hardreset_i,
    output logic                 dmi_tdo_o,
    output logic [1:0]           dmi_error_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [31:0]          dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int DrWidth = AddrWidth + 34;

    typedef enum logic [1:0] {Idle, Read, Write, WaitResp} state_e;

    state_e               state_q;
    logic [DrWidth-1:0]   dr_q;
    dmi_dr_t              dr_low;
    logic [AddrWidth-1:0] dr_addr;
    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth-1:0] req_addr_q;
    logic [31:0]          data_q;
    logic [31:0]          req_data_q;
    logic [1:0]           req_op_q;
    logic [1:0]           error_q;
    logic [1:0]           error_d;
    logic                 req_valid_q;
    logic                 resp_ready_q;
    logic                 capture;
    logic                 shift;
    logic                 update;
    logic                 busy;
    logic                 op_rw;
    logic                 accept;
    logic                 resp_fire;
    logic                 hard_abort;

`ifdef DMI_HARDRESET_EN
    assign hard_abort = dmi_hardreset_i;
`else
    logic unused_hardreset;
    assign hard_abort       = 1'b0;
    assign unused_hardreset = dmi_hardreset_i;
`endif

    assign dr_low    = dmi_dr_t'(dr_q[33:0]);
    assign dr_addr   = dr_q[DrWidth-1:34];
    assign capture   = dmi_access_i & capture_dr_i;
    assign shift     = dmi_access_i & shift_dr_i;
    assign update    = dmi_access_i & update_dr_i;
    assign busy      = (state_q != Idle);
    assign op_rw     = (dr_low.op == DTM_READ) || (dr_low.op == DTM_WRITE);
    assign accept    = update && !busy && (error_q == DTM_SUCCESS) && op_rw;
    assign resp_fire = (state_q == WaitResp) && dmi_resp_valid_i;

    // Sticky error: first error wins, busy beats failed, any clear beats a set.
    always_comb begin
        error_d = error_q;
        if (error_q == DTM_SUCCESS) begin
            if ((capture || update) && busy) begin
                error_d = DTM_BUSY;
            end else if (resp_fire && (dmi_resp_resp_i != 2'd0)) begin
                error_d = DTM_ERR;
            end
        end
        if (dmi_reset_i || test_logic_reset_i || hard_abort) begin
            error_d = DTM_SUCCESS;
        end
    end

    // Data register: capture the status view, then shift LSB-first towards TDO.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dr_q <= '0;
        end else if (test_logic_reset_i) begin
            dr_q <= '0;
        end else if (capture) begin
            dr_q <= {addr_q, data_q, error_d};
        end else if (shift) begin
            dr_q <= {dmi_tdi_i, dr_q[DrWidth-1:1]};
        end
    end

    // Address/data/status seen by the debugger on the next capture.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= '0;
        end else begin
            error_q <= error_d;
            if (test_logic_reset_i) begin
                addr_q <= '0;
                data_q <= '0;
            end else if (accept) begin
                addr_q <= dr_addr;
                if (dr_low.op == DTM_WRITE) begin
                    data_q <= dr_low.data;
                end
            end else if (resp_fire && (req_op_q == DTM_READ)) begin
                data_q <= dmi_resp_data_i;
            end
        end
    end

    // Bus-side FSM; the request payload has its own copy so a TAP reset
    // cannot disturb a request that is already on the bus.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q      <= Idle;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_op_q     <= '0;
        end else if (hard_abort) begin
            state_q      <= Idle;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                Idle: begin
                    if (accept) begin
                        state_q     <= (dr_low.op == DTM_WRITE) ? Write : Read;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= dr_addr;
                        req_op_q    <= dr_low.op;
                        req_data_q  <= (dr_low.op == DTM_WRITE) ? dr_low.data : 32'h0;
                    end
                end
                Read, Write: begin
                    if (dmi_req_ready_i) begin
                        state_q      <= WaitResp;
                        req_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                    end
                end
                WaitResp: begin
                    if (dmi_resp_valid_i) begin
                        state_q      <= Idle;
                        resp_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= Idle;
                    req_valid_q  <= 1'b0;
                    resp_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign dmi_tdo_o        = dr_q[0];
    assign dmi_error_o      = error_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = req_addr_q;
    assign dmi_req_data_o   = req_data_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dmi_access_dr.sv
// Self-checking bench for dmi_access_dr: directed table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_dmi_access_dr;
    import dm_pkg::*;

    localparam int AW = 7;
    localparam int N  = AW + 34;

    logic          tck = 1'b0;
    logic          trst_n = 1'b0;
    logic          test_logic_reset_i = 1'b0;
    logic          dmi_access_i = 1'b0;
    logic          capture_dr_i = 1'b0;
    logic          shift_dr_i = 1'b0;
    logic          update_dr_i = 1'b0;
    logic          dmi_tdi_i = 1'b0;
    logic          dmi_reset_i = 1'b0;
    logic          dmi_hardreset_i = 1'b0;
    logic          dmi_tdo_o;
    logic [1:0]    dmi_error_o;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i = 1'b0;
    logic [AW-1:0] dmi_req_addr_o;
    logic [31:0]   dmi_req_data_o;
    logic [1:0]    dmi_req_op_o;
    logic          dmi_resp_valid_i = 1'b0;
    logic          dmi_resp_ready_o;
    logic [31:0]   dmi_resp_data_i = 32'h0;
    logic [1:0]    dmi_resp_resp_i = 2'd0;

    dmi_access_dr #(.AddrWidth(AW)) dut (
        .tck_i              (tck),
        .trst_ni            (trst_n),
        .test_logic_reset_i (test_logic_reset_i),
        .dmi_access_i       (dmi_access_i),
        .capture_dr_i       (capture_dr_i),
        .shift_dr_i         (shift_dr_i),
        .update_dr_i        (update_dr_i),
        .dmi_tdi_i          (dmi_tdi_i),
        .dmi_reset_i        (dmi_reset_i),
        .dmi_hardreset_i    (dmi_hardreset_i),
        .dmi_tdo_o          (dmi_tdo_o),
        .dmi_error_o        (dmi_error_o),
        .dmi_req_valid_o    (dmi_req_valid_o),
        .dmi_req_ready_i    (dmi_req_ready_i),
        .dmi_req_addr_o     (dmi_req_addr_o),
        .dmi_req_data_o     (dmi_req_data_o),
        .dmi_req_op_o       (dmi_req_op_o),
        .dmi_resp_valid_i   (dmi_resp_valid_i),
        .dmi_resp_ready_o   (dmi_resp_ready_o),
        .dmi_resp_data_i    (dmi_resp_data_i),
        .dmi_resp_resp_i    (dmi_resp_resp_i)
    );

    always #5 tck = ~tck;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;

    always @(posedge tck) if (dmi_req_valid_o && dmi_req_ready_i) hs_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    function automatic logic [41:0] req_vec();
        return {dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o};
    endfunction

    function automatic logic [41:0] exp_req(input logic [1:0] op, input logic [AW-1:0] a,
                                            input logic [31:0] d);
        return {1'b1, a, op, (op == 2'd2) ? d : 32'h0};
    endfunction

    // Full TAP scan: capture, shift N bits in (returning what came out), update.
    task automatic scan(input logic acc, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [31:0] d, output logic [N-1:0] cap);
        logic [N-1:0] din;
        din = {a, d, op};
        dmi_access_i = acc;
        capture_dr_i = 1'b1;
        tick();
        capture_dr_i = 1'b0;
        shift_dr_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            dmi_tdi_i = din[i];
            cap[i] = dmi_tdo_o;
            tick();
        end
        shift_dr_i = 1'b0;
        dmi_tdi_i = 1'b0;
        update_dr_i = 1'b1;
        tick();
        update_dr_i = 1'b0;
        dmi_access_i = 1'b0;
    endtask

    task automatic pulse_capture();
        dmi_access_i = 1'b1;
        capture_dr_i = 1'b1;
        tick();
        capture_dr_i = 1'b0;
        dmi_access_i = 1'b0;
    endtask

    task automatic pulse_dmi_reset();
        dmi_reset_i = 1'b1;
        tick();
        dmi_reset_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata, input logic [1:0] rresp);
        dmi_resp_data_i = rdata;
        dmi_resp_resp_i = rresp;
        dmi_resp_valid_i = 1'b1;
        tick();
        dmi_resp_valid_i = 1'b0;
        dmi_resp_resp_i = 2'd0;
        dmi_resp_data_i = 32'h0;
        check("resp_done", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b00);
    endtask

    // Stall the request, checking it stays put, then handshake and respond.
    task automatic complete(input logic [41:0] exp, input int stall,
                            input logic [31:0] rdata, input logic [1:0] rresp);
        dmi_req_ready_i = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check("req_stable", req_vec(), exp);
            tick();
        end
        check("req_at_hs", req_vec(), exp);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        check("after_hs", {dmi_req_valid_o, dmi_resp_ready_o}, 2'b01);
        respond(rdata, rresp);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   rdata;
        logic [1:0]    rresp;
        logic          clr;
        logic          exp_req;
        logic [AW-1:0] cap_addr;
        logic [31:0]   cap_data;
        logic [1:0]    cap_err;
        logic [1:0]    exp_err;
    } vec_t;

    vec_t          tbl[8];
    logic [N-1:0]  cap;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;
    logic [1:0]    m_err;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;
    logic          r_accept;
    int            hs0;

    initial begin
        tbl[0] = '{2'd2, 7'h10, 32'hDEADBEEF, 32'h0,        2'd0, 1'b0, 1'b1, 7'h00, 32'h00000000, 2'd0, 2'd0};
        tbl[1] = '{2'd1, 7'h11, 32'h0,        32'h12345678, 2'd0, 1'b0, 1'b1, 7'h10, 32'hDEADBEEF, 2'd0, 2'd0};
        tbl[2] = '{2'd0, 7'h22, 32'hFFFFFFFF, 32'h0,        2'd0, 1'b0, 1'b0, 7'h11, 32'h12345678, 2'd0, 2'd0};
        tbl[3] = '{2'd2, 7'h05, 32'hCAFEF00D, 32'h0,        2'd2, 1'b0, 1'b1, 7'h11, 32'h12345678, 2'd0, 2'd2};
        tbl[4] = '{2'd2, 7'h06, 32'h11111111, 32'h0,        2'd0, 1'b0, 1'b0, 7'h05, 32'hCAFEF00D, 2'd2, 2'd2};
        tbl[5] = '{2'd1, 7'h07, 32'h0,        32'h0,        2'd0, 1'b1, 1'b0, 7'h05, 32'hCAFEF00D, 2'd2, 2'd2};
        tbl[6] = '{2'd3, 7'h08, 32'h22222222, 32'h0,        2'd0, 1'b0, 1'b0, 7'h05, 32'hCAFEF00D, 2'd0, 2'd0};
        tbl[7] = '{2'd1, 7'h7F, 32'h0,        32'hA5A5A5A5, 2'd0, 1'b0, 1'b1, 7'h05, 32'hCAFEF00D, 2'd0, 2'd0};

        // Reset state
        #12;
        check("rst_outputs", {dmi_tdo_o, dmi_error_o, dmi_resp_ready_o, req_vec()}, 64'h0);
        @(negedge tck);
        trst_n = 1'b1;
        tick();

        // Directed table: write, read, nop, failed write, sticky error, reserved op
        for (int i = 0; i < 8; i++) begin
            scan(1'b1, tbl[i].op, tbl[i].addr, tbl[i].data, cap);
            check("tbl_cap", cap, {tbl[i].cap_addr, tbl[i].cap_data, tbl[i].cap_err});
            if (tbl[i].exp_req) begin
                complete(exp_req(tbl[i].op, tbl[i].addr, tbl[i].data), 1, tbl[i].rdata, tbl[i].rresp);
            end else begin
                tick();
                check("tbl_noreq", dmi_req_valid_o, 1'b0);
            end
            check("tbl_err", dmi_error_o, tbl[i].exp_err);
            if (tbl[i].clr) begin
                pulse_dmi_reset();
                check("tbl_clr", dmi_error_o, 2'd0);
            end
        end

        // Busy + long stall: capture during stall reports busy, its update is dropped
        scan(1'b1, 2'd2, 7'h33, 32'h0BADF00D, cap);
        hs0 = hs_count;
        dmi_req_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_stable", req_vec(), exp_req(2'd2, 7'h33, 32'h0BADF00D));
            tick();
        end
        scan(1'b1, 2'd1, 7'h44, 32'h0, cap);
        check("busy_cap", cap, {7'h33, 32'h0BADF00D, 2'd3});
        check("busy_err", dmi_error_o, 2'd3);
        complete(exp_req(2'd2, 7'h33, 32'h0BADF00D), 2, 32'h0, 2'd0);
        tick();
        check("busy_single_hs", hs_count - hs0, 1);
        check("busy_no_extra_req", dmi_req_valid_o, 1'b0);
        scan(1'b1, 2'd0, 7'h0, 32'h0, cap);
        check("busy_update_ignored", cap, {7'h33, 32'h0BADF00D, 2'd3});
        pulse_dmi_reset();
        check("busy_cleared", dmi_error_o, 2'd0);

        // dmi_reset beats a same-cycle busy set
        scan(1'b1, 2'd1, 7'h09, 32'h0, cap);
        dmi_access_i = 1'b1;
        capture_dr_i = 1'b1;
        dmi_reset_i = 1'b1;
        tick();
        dmi_access_i = 1'b0;
        capture_dr_i = 1'b0;
        dmi_reset_i = 1'b0;
        check("reset_wins", dmi_error_o, 2'd0);
        complete(exp_req(2'd1, 7'h09, 32'h0), 0, 32'h600DCAFE, 2'd0);

        // Scans with dmi_access low do nothing
        scan(1'b0, 2'd2, 7'h55, 32'h77777777, cap);
        tick();
        check("no_access_noreq", dmi_req_valid_o, 1'b0);
        scan(1'b1, 2'd0, 7'h0, 32'h0, cap);
        check("no_access_cap", cap, {7'h09, 32'h600DCAFE, 2'd0});

        // Hard reset while waiting for a response
        scan(1'b1, 2'd2, 7'h21, 32'h55AA55AA, cap);
        dmi_req_ready_i = 1'b1;
        tick();
        dmi_req_ready_i = 1'b0;
        check("hr_waitresp", dmi_resp_ready_o, 1'b1);
        pulse_capture();
        check("hr_busy", dmi_error_o, 2'd3);
        dmi_hardreset_i = 1'b1;
        tick();
        dmi_hardreset_i = 1'b0;
`ifdef DMI_HARDRESET_EN
        check("hr_abort", {dmi_req_valid_o, dmi_resp_ready_o, dmi_error_o}, 4'b0000);
        scan(1'b1, 2'd2, 7'h22, 32'h01020304, cap);
        complete(exp_req(2'd2, 7'h22, 32'h01020304), 0, 32'h0, 2'd0);
        check("hr_new_write_err", dmi_error_o, 2'd0);
`else
        check("hr_ignored", {dmi_req_valid_o, dmi_resp_ready_o, dmi_error_o}, 4'b0111);
        respond(32'h0, 2'd0);
        pulse_dmi_reset();
        check("hr_ignored_clr", dmi_error_o, 2'd0);
`endif

        // TAP reset during an outstanding write: DR/status cleared, request untouched
        scan(1'b1, 2'd2, 7'h12, 32'h11223344, cap);
        pulse_capture();
        check("tlr_pre_tdo", dmi_tdo_o, 1'b1);
        test_logic_reset_i = 1'b1;
        tick();
        test_logic_reset_i = 1'b0;
        check("tlr_clear", {dmi_tdo_o, dmi_error_o}, 3'b000);
        complete(exp_req(2'd2, 7'h12, 32'h11223344), 2, 32'h0, 2'd0);
        scan(1'b1, 2'd0, 7'h0, 32'h0, cap);
        check("tlr_cap", cap, '0);

        // Randomized transactions against a debugger-visible model
        m_addr = '0;
        m_data = '0;
        m_err  = 2'd0;
        for (int it = 0; it < 40; it++) begin
            r_op   = 2'($urandom_range(3, 0));
            r_addr = AW'($urandom);
            r_data = $urandom;
            scan(1'b1, r_op, r_addr, r_data, cap);
            check("rnd_cap", cap, {m_addr, m_data, m_err});
            r_accept = (m_err == 2'd0) && (r_op == 2'd1 || r_op == 2'd2);
            if (r_accept) begin
                m_addr = r_addr;
                if (r_op == 2'd2) m_data = r_data;
                hs0 = hs_count;
                dmi_req_ready_i = 1'b0;
                if ($urandom_range(3, 0) == 0) begin
                    scan(1'b1, 2'($urandom_range(3, 0)), AW'($urandom), $urandom, cap);
                    check("rnd_busy_cap", cap, {m_addr, m_data, 2'd3});
                    m_err = 2'd3;
                end
                r_rdata = $urandom;
                r_rresp = ($urandom_range(3, 0) == 0) ? 2'd2 : 2'd0;
                complete(exp_req(r_op, r_addr, r_data), int'($urandom_range(4, 0)), r_rdata, r_rresp);
                if (r_op == 2'd1) m_data = r_rdata;
                if (r_rresp != 2'd0 && m_err == 2'd0) m_err = 2'd2;
                check("rnd_hs", hs_count - hs0, 1);
            end else begin
                tick();
                check("rnd_noreq", dmi_req_valid_o, 1'b0);
            end
            check("rnd_err", dmi_error_o, m_err);
            if ($urandom_range(3, 0) == 0 || (m_err != 2'd0 && $urandom_range(1, 0) == 1)) begin
                pulse_dmi_reset();
                m_err = 2'd0;
                check("rnd_clr", dmi_error_o, m_err);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmi_access_dr.md
DMI_ACCESS_DR -- requirements
Module: dmi_access_dr

Interface
REQ-001 SHALL have parameter AddrWidth, default 7, giving the DMI address width (abits); DR width N = AddrWidth+34.
REQ-002 SHALL have port tck_i, input, 1, JTAG test clock; all state on its rising edge.
REQ-003 SHALL have port trst_ni, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have TAP inputs, 1 bit each: test_logic_reset_i, dmi_access_i, capture_dr_i, shift_dr_i, update_dr_i, dmi_tdi_i, dmi_reset_i, dmi_hardreset_i.
REQ-005 SHALL have dmi_tdo_o, output, 1, serial data to TAP; dmi_error_o, output, 2, sticky status to TAP dtmcs.dmistat.
REQ-006 SHALL have request port: dmi_req_valid_o out 1, dmi_req_ready_i in 1, dmi_req_addr_o out AddrWidth, dmi_req_data_o out 32, dmi_req_op_o out 2.
REQ-007 SHALL have response port: dmi_resp_valid_i in 1, dmi_resp_ready_o out 1, dmi_resp_data_i in 32, dmi_resp_resp_i in 2 (0 = ok).

Function
REQ-008 DR layout SHALL be {addr[N-1:34], data[33:2], op[1:0]}; op: 0 nop, 1 read, 2 write, 3 reserved.
REQ-009 While dmi_access_i and shift_dr_i, DR SHALL shift right one bit per cycle, dmi_tdi_i into bit N-1; dmi_tdo_o = DR[0] combinationally.
REQ-010 FSM states SHALL be Idle, Read, Write, WaitResp; reset state Idle.
REQ-011 On dmi_access_i and capture_dr_i: if FSM != Idle and error_q == 0, error_q SHALL become 3 (busy); DR SHALL load {addr_q, data_q, error_q-after-update}.
REQ-012 On dmi_access_i and update_dr_i with FSM Idle and error_q == 0: op 1 SHALL latch addr_q, go Read; op 2 SHALL latch addr_q and data_q, go Write; op 0/3 SHALL be ignored.
REQ-013 On update_dr_i with FSM != Idle SHALL set error_q=3 and ignore op; with error_q != 0 SHALL ignore op entirely.
REQ-014 In Read/Write, dmi_req_valid_o SHALL be 1 with addr_q, op 1/2, data data_q (0 for read); valid first asserts the cycle after update_dr_i.
REQ-015 Once asserted, dmi_req_valid_o and payload SHALL hold stable until dmi_req_ready_i; on handshake FSM SHALL go WaitResp.
REQ-016 In WaitResp dmi_resp_ready_o SHALL be 1; on dmi_resp_valid_i FSM SHALL go Idle; a read SHALL load data_q from dmi_resp_data_i; dmi_resp_resp_i != 0 with error_q == 0 SHALL set error_q=2.
REQ-017 dmi_error_o SHALL equal error_q; error_q is sticky, cleared only by dmi_reset_i, test_logic_reset_i, or reset.
REQ-018 dmi_reset_i SHALL clear error_q and SHALL win over any same-cycle error set.
REQ-019 test_logic_reset_i SHALL clear DR, addr_q, data_q, error_q; an outstanding transaction SHALL complete normally (handshake not violated).
REQ-020 Capture/shift/update SHALL have no effect when dmi_access_i is 0.

Reset
REQ-021 On trst_ni low: FSM Idle, DR/addr_q/data_q/error_q zero; all outputs 0 (dmi_tdo_o 0, valid/ready 0).

Configuration
REQ-022 Macro DMI_HARDRESET_EN defined: dmi_hardreset_i SHALL force FSM Idle, error_q 0, drop dmi_req_valid_o next cycle (abort); undefined: dmi_hardreset_i SHALL be ignored, port retained.

Structure
REQ-023 dtm_op_e (nop/read/write), status codes (ok 0, failed 2, busy 3) and the DR struct SHALL live in the shared dm package; FSM enum stays local.
REQ-024 No sub-module; single flat module.

Verification
REQ-025 Write: shift op=2 addr=0x10 data=0xDEADBEEF, update -> one req addr 0x10 op 2 data 0xDEADBEEF; error 0.
REQ-026 Read: op=1 addr=0x11, resp data 0x12345678 resp 0; next capture/shift -> DR out {0x11, 0x12345678, 0}.
REQ-027 Busy: hold dmi_req_ready_i 0, capture -> dmi_error_o 3, captured op field 3; next update ignored; dmi_reset_i -> 0.
REQ-028 Failed: resp_resp=2 -> dmi_error_o 2; further updates issue no request until dmi_reset_i.
REQ-029 Stall: ready low 5 cycles -> valid and payload stable throughout, single handshake.
REQ-030 DMI_HARDRESET_EN: hardreset while in WaitResp -> FSM Idle, error 0, new write accepted next update.
